// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Optional illegal-function bypass: define ALU_SHARE_FUNC_CHECK_EN.
module alu_share_arbiter #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [size-1:0] req0_a,
  input  logic [size-1:0] req0_b,
  input  logic [2:0]      req0_func,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [size-1:0] req1_a,
  input  logic [size-1:0] req1_b,
  input  logic [2:0]      req1_func,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [size-1:0] resp_data,
  output logic            resp_zero,
  output logic            resp_err,
  output logic [size-1:0] alu_a,
  output logic [size-1:0] alu_b,
  output logic [2:0]      alu_func,
  input  logic [size-1:0] alu_out,
  input  logic            alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            rr_last_q, rr_last_d;
  logic            gnt_id_q, gnt_id_d;
  logic [size-1:0] a_q, a_d;
  logic [size-1:0] b_q, b_d;
  logic [2:0]      func_q, func_d;
  logic [size-1:0] data_q, data_d;
  logic            zero_q, zero_d;

  logic            gnt;
  logic            accept;
  logic            resp_hs;
  logic [size-1:0] sel_a;
  logic [size-1:0] sel_b;
  logic [2:0]      sel_func;

`ifdef ALU_SHARE_FUNC_CHECK_EN
  logic            err_q, err_d;
  logic            illegal;
`endif

  // On a conflict the requester that did not win last time gets the grant.
  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt = ~rr_last_q;
    end else if (req1_valid) begin
      gnt = 1'b1;
    end
  end

  assign accept = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;

  assign sel_a    = gnt ? req1_a    : req0_a;
  assign sel_b    = gnt ? req1_b    : req0_b;
  assign sel_func = gnt ? req1_func : req0_func;

  assign resp_hs = gnt_id_q ? resp1_ready : resp0_ready;

`ifdef ALU_SHARE_FUNC_CHECK_EN
  assign illegal = (sel_func[2:1] == 2'b11);
`endif

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    gnt_id_d  = gnt_id_q;
    a_d       = a_q;
    b_d       = b_q;
    func_d    = func_q;
    data_d    = data_q;
    zero_d    = zero_q;
`ifdef ALU_SHARE_FUNC_CHECK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_id_d  = gnt;
          rr_last_d = gnt;
`ifdef ALU_SHARE_FUNC_CHECK_EN
          if (illegal) begin
            data_d  = '0;
            zero_d  = 1'b1;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            a_d     = sel_a;
            b_d     = sel_b;
            func_d  = sel_func;
            state_d = EXEC;
          end
`else
          a_d     = sel_a;
          b_d     = sel_b;
          func_d  = sel_func;
          state_d = EXEC;
`endif
        end
      end
      EXEC: begin
        data_d  = alu_out;
        zero_d  = alu_zero;
`ifdef ALU_SHARE_FUNC_CHECK_EN
        err_d   = 1'b0;
`endif
        state_d = RESP;
      end
      RESP: begin
        if (resp_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      gnt_id_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      func_q    <= '0;
      data_q    <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      gnt_id_q  <= gnt_id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      func_q    <= func_d;
      data_q    <= data_d;
      zero_q    <= zero_d;
    end
  end

`ifdef ALU_SHARE_FUNC_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign req0_ready  = accept && !gnt;
  assign req1_ready  = accept && gnt;
  assign resp0_valid = (state_q == RESP) && !gnt_id_q;
  assign resp1_valid = (state_q == RESP) && gnt_id_q;
  assign resp_data   = data_q;
  assign resp_zero   = zero_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_func    = func_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural shared ALU.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_func, req1_func;
  logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [W-1:0] resp_data;
  logic         resp_zero, resp_err;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_func;
  logic         alu_zero;

  int total = 0;
  int bad = 0;

  alu_share_arbiter #(.size(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // Shared ALU sitting outside the arbiter.
  always_comb begin
    alu_out = '0;
    case (alu_func)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a | alu_b;
      3'd4: alu_out = ~(alu_a | alu_b);
      3'd5: alu_out = alu_a << alu_b[4:0];
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 5; req0_b = 7; req0_func = 0;
    req1_valid = 1'b0; req1_a = 0; req1_b = 0; req1_func = 0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", req0_ready); end
    total++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b%b want=00", resp0_valid, resp1_valid); end
    total++; if (resp_data !== 0 || resp_zero !== 1'b0 || resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp got=%0h/%b/%b want=0/0/0", resp_data, resp_zero, resp_err); end
    total++; if (alu_a !== 0 || alu_b !== 0 || alu_func !== 0) begin bad++; $display("FAIL rst_alu got=%0h/%0h/%0d want=0/0/0", alu_a, alu_b, alu_func); end
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 5; req0_b = 7; req0_func = 0;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL add_ready got=%b%b want=10", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    total++; if (alu_a !== 5 || alu_b !== 7 || alu_func !== 0) begin bad++; $display("FAIL add_exec_alu got=%0h/%0h/%0d want=5/7/0", alu_a, alu_b, alu_func); end
    total++; if (resp0_valid !== 1'b0) begin bad++; $display("FAIL add_early_resp got=%b want=0", resp0_valid); end
    @(negedge clk); #1;
    total++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0) begin bad++; $display("FAIL add_resp_valid got=%b%b want=10", resp0_valid, resp1_valid); end
    total++; if (resp_data !== 12 || resp_zero !== 1'b0) begin bad++; $display("FAIL add_result got=%0h/%b want=c/0", resp_data, resp_zero); end
    resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    #1;
    total++; if (resp0_valid !== 1'b0) begin bad++; $display("FAIL add_resp_drop got=%b want=0", resp0_valid); end
  endtask

  task automatic test_hold;
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 9; req1_b = 9; req1_func = 1;
    req0_valid = 1'b1; req0_a = 1; req0_b = 1; req0_func = 0;
    #1;
    total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++; $display("FAIL hold_grant got=%b%b want=01", req0_ready, req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    resp0_ready = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL hold_exec_ready got=%b want=0", req0_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0) begin bad++; $display("FAIL hold_valid[%0d] got=%b%b want=01", i, resp0_valid, resp1_valid); end
      total++; if (resp_data !== 0 || resp_zero !== 1'b1) begin bad++; $display("FAIL hold_data[%0d] got=%0h/%b want=0/1", i, resp_data, resp_zero); end
      total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL hold_req0_ready[%0d] got=%b want=0", i, req0_ready); end
    end
    resp0_ready = 1'b0;
    req0_valid = 1'b0;
    resp1_ready = 1'b1;
    @(negedge clk);
    resp1_ready = 1'b0;
    #1;
    total++; if (resp1_valid !== 1'b0) begin bad++; $display("FAIL hold_drop got=%b want=0", resp1_valid); end
  endtask

  task automatic test_back_to_back;
    logic exp_id;
    logic [W-1:0] exp_data;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'hF0; req0_b = 32'h0F; req0_func = 3;
    req1_valid = 1'b1; req1_a = 1; req1_b = 4; req1_func = 5;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_id = i[0];
      exp_data = exp_id ? 32'h10 : 32'hFF;
      total++; if (req0_ready !== !exp_id || req1_ready !== exp_id) begin bad++; $display("FAIL b2b_grant[%0d] got=%b%b want_id=%0d", i, req0_ready, req1_ready, exp_id); end
      @(negedge clk); #1;
      total++; if (alu_func !== (exp_id ? 3'd5 : 3'd3)) begin bad++; $display("FAIL b2b_func[%0d] got=%0d want=%0d", i, alu_func, exp_id ? 5 : 3); end
      @(negedge clk); #1;
      total++; if (resp0_valid !== !exp_id || resp1_valid !== exp_id) begin bad++; $display("FAIL b2b_resp[%0d] got=%b%b want_id=%0d", i, resp0_valid, resp1_valid, exp_id); end
      total++; if (resp_data !== exp_data) begin bad++; $display("FAIL b2b_data[%0d] got=%0h want=%0h", i, resp_data, exp_data); end
      @(negedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 0; req0_b = 0; req0_func = 4;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL rmid_accept got=%b want=1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    total++; if (alu_func !== 3'd4) begin bad++; $display("FAIL rmid_exec_func got=%0d want=4", alu_func); end
    rst = 1'b1;
    #1;
    total++; if (alu_func !== 0 || resp0_valid !== 1'b0) begin bad++; $display("FAIL rmid_async got=%0d/%b want=0/0", alu_func, resp0_valid); end
    @(negedge clk); #1;
    total++; if (resp0_valid !== 1'b0 || resp_data !== 0 || resp_zero !== 1'b0) begin bad++; $display("FAIL rmid_no_resp got=%b/%0h/%b want=0/0/0", resp0_valid, resp_data, resp_zero); end
    rst = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 2; req0_b = 3; req0_func = 0;
    req1_valid = 1'b1; req1_a = 1; req1_b = 1; req1_func = 2;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL rmid_prio got=%b%b want=10", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    total++; if (resp0_valid !== 1'b1 || resp_data !== 5) begin bad++; $display("FAIL rmid_after got=%b/%0h want=1/5", resp0_valid, resp_data); end
    resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
  endtask

  task automatic test_illegal;
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 3; req1_b = 4; req1_func = 6;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL ill_accept got=%b want=1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
`ifdef ALU_SHARE_FUNC_CHECK_EN
    total++; if (resp1_valid !== 1'b1) begin bad++; $display("FAIL ill_fast_valid got=%b want=1", resp1_valid); end
    total++; if (resp_data !== 0 || resp_zero !== 1'b1 || resp_err !== 1'b1) begin bad++; $display("FAIL ill_fast_resp got=%0h/%b/%b want=0/1/1", resp_data, resp_zero, resp_err); end
    total++; if (alu_a !== 2 || alu_func !== 0) begin bad++; $display("FAIL ill_alu_kept got=%0h/%0d want=2/0", alu_a, alu_func); end
`else
    total++; if (resp1_valid !== 1'b0) begin bad++; $display("FAIL ill_early got=%b want=0", resp1_valid); end
    @(negedge clk); #1;
    total++; if (resp1_valid !== 1'b1) begin bad++; $display("FAIL ill_valid got=%b want=1", resp1_valid); end
    total++; if (resp_data !== 0 || resp_zero !== 1'b1 || resp_err !== 1'b0) begin bad++; $display("FAIL ill_resp got=%0h/%b/%b want=0/1/0", resp_data, resp_zero, resp_err); end
`endif
    resp1_ready = 1'b1;
    @(negedge clk);
    resp1_ready = 1'b0;
    #1;
    total++; if (resp1_valid !== 1'b0) begin bad++; $display("FAIL ill_drop got=%b want=0", resp1_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Sequencer/arbiter that shares one combinational ALU instance between two requesters (e.g. the execute stage and a multi-cycle helper unit).
- Accepts operations over valid/ready handshakes and grants access round-robin.
- Registers operands, drives the external ALU for one cycle, captures result and zero flag, and returns them with a response handshake.
- One transaction in flight at a time.

Parameters:
- size, 32, datapath width of operands and result; must match the shared ALU's width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid / req1_valid  input  1  requester N presents an operation.
- req0_ready / req1_ready  output  1  operation accepted this cycle when ready and valid are both high.
- req0_a, req0_b / req1_a, req1_b  input  size  operands.
- req0_func / req1_func  input  3  ALU function code (0 add, 1 sub, 2 and, 3 or, 4 nor, 5 shift-left, 6-7 yield 0).
- resp0_valid / resp1_valid  output  1  result available for requester N.
- resp0_ready / resp1_ready  input  1  requester N consumes its result.
- resp_data  output  size  captured ALU result, shared by both responders.
- resp_zero  output  1  captured ALU zero flag.
- resp_err  output  1  illegal-function flag (see Optional Feature).
- alu_a, alu_b  output  size  operands driven to the shared ALU.
- alu_func  output  3  function code driven to the shared ALU.
- alu_out  input  size  ALU result.
- alu_zero  input  1  ALU zero flag.

Behaviour:
- Async reset (rst high, effective immediately, no clock needed):
  - state=IDLE, rr_last=1 so requester 0 has priority on the first conflict.
  - Operand/func registers, resp_data, resp_zero, resp_err all 0; all resp_valid 0.
  - req_ready forced 0 while rst is high.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Combinational grant. If exactly one req_valid is high, grant it. If both are high, grant the requester not equal to rr_last.
  - reqN_ready = granted requester only, and only in IDLE.
  - On accept: latch a, b, func into operand registers; record grant id; rr_last<=grant; next state EXEC. With no valid, stay IDLE.
- EXEC:
  - alu_a/alu_b/alu_func are driven from the operand registers at all times, so they are stable for the full EXEC cycle.
  - At end of cycle: resp_data<=alu_out, resp_zero<=alu_zero, resp_err<=0; next state RESP.
- RESP:
  - respN_valid=1 for the granted id only; resp_data/zero/err held stable.
  - On respN_ready: drop valid, go IDLE. Otherwise hold indefinitely.
  - No new request is accepted while in EXEC or RESP.
- Latency: accept edge T, EXEC during T+1, resp_valid high from cycle T+2. Best-case throughput is one op per 3 cycles; a new accept is possible the cycle after resp handshake.
- Arithmetic: entirely the ALU's. This block performs no computation and passes full size-bit values unmodified.
- Boundary conditions:
  - Both requesters valid on consecutive transactions: grants strictly alternate.
  - A valid request that is not granted must remain asserted and stable; it is not latched.
  - resp_ready high outside RESP is ignored.
  - resp_ready for the non-granted id is ignored.
  - Reset mid-EXEC or mid-RESP: transaction dropped, no response issued, state IDLE.

Optional Feature:
- Macro ALU_SHARE_FUNC_CHECK_EN.
- Defined: on accept, func 6 or 7 is flagged illegal. The FSM goes IDLE->RESP directly, skipping EXEC, so latency is 1 cycle. It responds with resp_data=0, resp_zero=1, resp_err=1, and alu_* operand registers are not updated.
- Undefined: every func goes through EXEC (ALU returns 0, zero=1); resp_err is tied 0.

Test Plan:
- Reset then req0 add a=5,b=7 -> req0_ready pulse, alu_func=0 during EXEC, resp0_valid 2 cycles after accept with resp_data=12, resp_zero=0.
- req1 sub a=9,b=9 with resp1_ready held low 4 cycles -> resp1_valid held, resp_data=0, resp_zero=1 stable; req0_valid meanwhile gets no ready.
- Both valid continuously for 4 ops (req0 or 0xF0|0x0F, req1 shift 1<<4) -> grant order 0,1,0,1; results 0xFF and 0x10.
- Assert rst during EXEC of req0 nor(0,0) -> no resp0_valid, outputs 0, next request accepted normally with requester 0 priority.
- func=6 a=3,b=4 -> with ALU_SHARE_FUNC_CHECK_EN: resp_valid 1 cycle after accept, data=0, err=1; without the macro: 2 cycles, data=0, zero=1, err=0.
